mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit in the CPU MEM stage, directly upstream of the data memory.
- Takes one memory request per cycle from the pipeline over a valid/ready handshake.
- Drives the data memory's write enable, address, per-byte write select and replicated write data.
- Data memory read data is registered, so it arrives one cycle after the address. This block captures it, aligns it, and sign- or zero-extends it.
- Returns a response (data, destination tag, fault flag) to writeback over a valid/ready handshake.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes. An address >= MEM_BYTES faults.
- TAG_W, 5: width of the destination register tag carried with each request.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads only: zero-extend when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_tag  in  TAG_W  destination tag
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_data  out  32  load result; 0 for a store; faulting address on a fault
- resp_tag  out  TAG_W  tag of the request
- resp_fault  out  1  request was misaligned, illegal size, or out of range
- dmem_we  out  1  memory write enable
- dmem_addr  out  32  memory byte address
- dmem_wdata_sel  out  4  per-byte write enable, bit i covers bits [8i+7:8i]
- dmem_wdata  out  32  replicated store data
- dmem_rdata  in  32  memory read data, valid one cycle after the address edge

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- States:
  - IDLE: no response pending.
  - LWAIT: load response comes from dmem_rdata this cycle.
  - HOLD: response comes from the internal register resp_q.
- Reset values: state IDLE; resp_valid 0; resp_data 0; resp_tag 0; resp_fault 0; all captured request fields 0.
- While rst is high: req_ready 0 and dmem_we 0.
- req_ready = !rst && (state == IDLE || resp_ready). The next request is accepted in the same cycle the current response leaves, giving 1 request per cycle.
- accept = req_valid && req_ready.
- fault = (req_size == 3) || (size half && addr[0]) || (size word && addr[1:0] != 0) || (req_addr >= MEM_BYTES).
- Memory side:
  - dmem_addr = req_addr, driven combinationally.
  - dmem_we = accept && req_we && !fault. A faulting store never writes.
  - dmem_wdata_sel:
    - byte: 4'b0001 << addr[1:0]
    - half: 4'b0011 << {addr[1], 1'b0}
    - word: 4'b1111
    - 0 whenever dmem_we is 0
  - dmem_wdata: byte is {4{wdata[7:0]}}; half is {2{wdata[15:0]}}; word is wdata.
- On accept, capture addr[1:0], size, unsigned and tag.
- Transitions on accept:
  - Load without fault: go to LWAIT.
  - Store, or any fault: load resp_q (data = 0 for a store, req_addr for a fault; fault flag; tag) and go to HOLD.
- Without accept, when the response is consumed: go to IDLE.
- LWAIT:
  - resp_valid = 1.
  - resp_data = extract(dmem_rdata): shift right by 8*offset, then sign- or zero-extend from bit 7 (byte) or bit 15 (half). Word passes through unchanged.
  - If !resp_ready: latch the extracted value into resp_q and go to HOLD. This is needed because dmem_rdata changes on the next edge.
- HOLD: resp_valid = 1. Outputs come from resp_q and stay stable until consumed.
- Load latency: accept edge to resp_valid is 1 cycle. Store and fault latency is also 1 cycle.
- Responses are returned in strict request order. At most one response is outstanding.
- Reset asserted mid-operation: outputs drop to reset values immediately, the pending response is discarded, and no write occurs.

Decomposition:
- Shared package holds:
  - size encodings SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2
  - state encodings IDLE / LWAIT / HOLD
  - constant MEM_BYTES default
- One combinational sub-module, mem_load_extract, with inputs rdata, offset, size and unsigned, producing the 32-bit result.

Test Plan:
- Byte store: store byte, addr 0x13, wdata 0x000000A5 → in the accept cycle dmem_we = 1, sel = 4'b1000, dmem_wdata = 0xA5A5A5A5. Next cycle resp_valid = 1, resp_data = 0, resp_fault = 0.
- Load extraction: preload word 0x10 = 0x80817F01, then:
  - lb 0x13 → 0xFFFFFF80
  - lbu 0x13 → 0x00000080
  - lh 0x12 → 0xFFFF8081
  - lhu 0x10 → 0x00007F01
  - lw 0x10 → 0x80817F01
- Back-to-back: 4 loads on consecutive cycles with resp_ready = 1 → 4 consecutive responses, tags 1..4 in order, req_ready stays 1.
- Backpressure: a load is accepted, then resp_ready = 0 for 3 cycles while req_addr changes → resp_data stays constant, req_ready = 0, and the response is consumed on the 4th cycle.
- Faults:
  - store word at 0x6 → dmem_we stays 0; resp_fault = 1, resp_data = 0x6
  - load word at 0x400 → resp_fault = 1
  - size 3 → resp_fault = 1
- Reset in LWAIT: assert rst → resp_valid = 0 without waiting for a clock edge. After release the block is in IDLE and no memory write occurred.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared encodings for the MEM-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Response state machine encodings
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;  // no response pending
    localparam state_t LWAIT = 2'd1;  // load data comes straight from dmem_rdata
    localparam state_t HOLD  = 2'd2;  // response held in the internal register

    // Default data memory size in bytes
    localparam int MEM_BYTES_DEFAULT = 1024;

endpackage
`default_nettype wire

// File: rtl/mem_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_extract
// Description : Aligns a memory read word by byte offset and sign- or
//               zero-extends it to 32 bits according to the access size.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Select and extend the addressed byte/half; words pass through
    always_comb begin
        o_data = w_shifted;
        case (i_size)
            SIZE_B: o_data = i_unsigned ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SIZE_H: o_data = i_unsigned ? {16'h0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit. Accepts one request per cycle,
//               drives the data memory, and returns aligned/extended load
//               data, store acknowledges or fault responses in order.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_fault,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_wdata_sel,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata
);

    localparam logic [31:0] c_mem_limit = 32'(MEM_BYTES);

    state_t            r_state;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [TAG_W-1:0]  r_tag;
    logic [31:0]       r_resp_data;
    logic              r_resp_fault;

    logic              w_accept;
    logic              w_fault;
    logic [31:0]       w_ext;

    // A new request may enter whenever the current response leaves this cycle
    assign req_ready = !rst && ((r_state == IDLE) || resp_ready);
    assign w_accept  = req_valid && req_ready;

    assign w_fault = (req_size == 2'd3)
                  || ((req_size == SIZE_H) && req_addr[0])
                  || ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00))
                  || (req_addr >= c_mem_limit);

    // Memory side: address passes through, faulting stores never write
    assign dmem_addr = req_addr;
    assign dmem_we   = w_accept && req_we && !w_fault;

    // Byte lane enables and replicated store data
    always_comb begin
        dmem_wdata_sel = 4'b0000;
        dmem_wdata     = req_wdata;
        case (req_size)
            SIZE_B: begin
                dmem_wdata_sel = 4'b0001 << req_addr[1:0];
                dmem_wdata     = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                dmem_wdata_sel = 4'b0011 << {req_addr[1], 1'b0};
                dmem_wdata     = {2{req_wdata[15:0]}};
            end
            default: begin
                dmem_wdata_sel = 4'b1111;
                dmem_wdata     = req_wdata;
            end
        endcase
        if (!dmem_we) begin
            dmem_wdata_sel = 4'b0000;
        end
    end

    mem_load_extract u_extract (
        .i_rdata    (dmem_rdata),
        .i_offset   (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    // In LWAIT the data is live from memory; otherwise it comes from the register
    assign resp_valid = (r_state != IDLE);
    assign resp_data  = (r_state == LWAIT) ? w_ext : r_resp_data;
    assign resp_tag   = r_tag;
    assign resp_fault = (r_state == HOLD) && r_resp_fault;

    // Response state machine and captured request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_off        <= 2'b00;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_tag        <= '0;
            r_resp_data  <= 32'h0;
            r_resp_fault <= 1'b0;
        end else if (w_accept) begin
            r_off      <= req_addr[1:0];
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_tag      <= req_tag;
            if (!req_we && !w_fault) begin
                r_state <= LWAIT;
            end else begin
                r_resp_data  <= w_fault ? req_addr : 32'h0;
                r_resp_fault <= w_fault;
                r_state      <= HOLD;
            end
        end else if ((r_state != IDLE) && resp_ready) begin
            r_state <= IDLE;
        end else if (r_state == LWAIT) begin
            // dmem_rdata moves on the next edge, so keep the stalled load value
            r_resp_data  <= w_ext;
            r_resp_fault <= 1'b0;
            r_state      <= HOLD;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a byte-lane data
//               memory model that returns registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_tag_w = 5;

    typedef struct {
        logic [31:0]        data;
        logic [c_tag_w-1:0] tag;
        logic               fault;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]         req_size;
    logic [31:0]        req_addr, req_wdata;
    logic [c_tag_w-1:0] req_tag;
    logic               resp_valid, resp_ready, resp_fault;
    logic [31:0]        resp_data;
    logic [c_tag_w-1:0] resp_tag;
    logic               dmem_we;
    logic [31:0]        dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]         dmem_wdata_sel;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   wr_count = 0;
    exp_t sb[$];
    int   rsp_cyc[$];
    logic [31:0] mem [0:255];

    mem_access_unit #(.MEM_BYTES(1024), .TAG_W(c_tag_w)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_fault(resp_fault),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata_sel(dmem_wdata_sel),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: byte-lane writes, read data registered one cycle
    always @(posedge clk) begin
        if (dmem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wdata_sel[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
            wr_count <= wr_count + 1;
        end
        dmem_rdata <= mem[dmem_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a response is consumed
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_response", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_data",  resp_data, e.data);
                check("resp_tag",   32'(resp_tag), 32'(e.tag));
                check("resp_fault", 32'(resp_fault), 32'(e.fault));
            end
            rsp_cyc.push_back(cyc);
        end
    end

    // Issue one request; optionally check memory-side outputs in the accept cycle
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [c_tag_w-1:0] tag,
                         input logic [31:0] exp_data, input logic exp_fault,
                         input logic chk_mem, input logic exp_we,
                         input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                         output int stalls);
        logic acc;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_tag = tag;
        stalls = 0;
        acc = 1'b0;
        while (!acc && stalls < 20) begin
            @(negedge clk);
            acc = req_ready;
            if (!acc) stalls++;
        end
        if (!acc) begin
            check("accept_timeout", 32'h0, 32'h1);
        end else begin
            if (chk_mem) begin
                check("dmem_we",  32'(dmem_we), 32'(exp_we));
                check("dmem_sel", 32'(dmem_wdata_sel), 32'(exp_sel));
                if (exp_we) check("dmem_wdata", dmem_wdata, exp_wd);
            end
            @(posedge clk);
            e.data = exp_data; e.tag = tag; e.fault = exp_fault;
            sb.push_back(e);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    int st, st_total, wc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_tag = '0;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data",  resp_data, 32'h0);
        check("rst_resp_tag",   32'(resp_tag), 32'h0);
        check("rst_resp_fault", 32'(resp_fault), 32'h0);
        check("rst_req_ready",  32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Byte store, then preload word 0x10 with a word store
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 5'd1, 32'h0, 1'b0,
              1'b1, 1'b1, 4'b1000, 32'hA5A5A5A5, st);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80817F01, 5'd2, 32'h0, 1'b0,
              1'b1, 1'b1, 4'b1111, 32'h80817F01, st);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 5'd3, 32'h0, 1'b0,
              1'b1, 1'b1, 4'b1100, 32'hBEEFBEEF, st);
        drain();

        // Load extraction
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd4, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, st);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd5, 32'h00000080, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, st);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5'd6, 32'hFFFF8081, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, st);
        issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 5'd7, 32'h00007F01, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, st);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd8, 32'h80817F01, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, st);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5'd9, 32'hFFFFBEEF, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, st);
        drain();

        // Back-to-back loads, tags 1..4
        rsp_cyc.delete();
        st_total = 0;
        for (int i = 1; i <= 4; i++) begin
            issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'(i), 32'h80817F01, 1'b0,
                  1'b0, 1'b0, 4'h0, 32'h0, st);
            st_total += st;
        end
        drain();
        check("b2b_stalls", 32'(st_total), 32'h0);
        check("b2b_count",  32'(rsp_cyc.size()), 32'd4);
        if (rsp_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("b2b_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd1);
        end

        // Backpressure: response held while the address wanders
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd12, 32'h80817F01, 1'b0,
              1'b0, 1'b0, 4'h0, 32'h0, st);
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(i * 4);
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'h1);
            check("bp_data",  resp_data, 32'h80817F01);
            check("bp_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        check("bp_pending", 32'(sb.size()), 32'h1);
        resp_ready = 1'b1;
        drain();

        // Faults
        wc = wr_count;
        issue(1'b1, 2'd2, 1'b0, 32'h6, 32'hDEADBEEF, 5'd13, 32'h6, 1'b1,
              1'b1, 1'b0, 4'b0000, 32'h0, st);
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd14, 32'h400, 1'b1,
              1'b1, 1'b0, 4'b0000, 32'h0, st);
        issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 5'd15, 32'h20, 1'b1,
              1'b1, 1'b0, 4'b0000, 32'h0, st);
        issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 5'd16, 32'h11, 1'b1,
              1'b0, 1'b0, 4'h0, 32'h0, st);
        drain();
        check("fault_no_write", 32'(wr_count - wc), 32'h0);

        // Reset while a load is in LWAIT
        resp_ready = 1'b0;
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd17, 32'hFFFFFF80, 1'b0,
              1'b0, 1'b0, 4'h0, 32'h0, st);
        wc = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'h12345678;
        rst = 1'b1;
        #1;
        check("arst_resp_valid", 32'(resp_valid), 32'h0);
        check("arst_resp_data",  resp_data, 32'h0);
        check("arst_resp_tag",   32'(resp_tag), 32'h0);
        check("arst_req_ready",  32'(req_ready), 32'h0);
        check("arst_dmem_we",    32'(dmem_we), 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        check("arst_no_write", 32'(wr_count - wc), 32'h0);
        @(negedge clk);
        check("post_rst_valid", 32'(resp_valid), 32'h0);
        check("post_rst_idle",  32'(req_ready), 32'h1);
        resp_ready = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
